// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer arbitration slice: state encoding,
// requester indices and the pad's silent level.
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int REQ_SOS   = 0;
    localparam int REQ_ALARM = 1;
    localparam int REQ_KEY   = 2;

    localparam logic PIN_SILENT = 1'b1;

    // The pad is considered owned (or cooling down) outside IDLE.
    function automatic logic is_busy(input state_t s);
        return (s == GRANT) || (s == GAP);
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond timebase: a tick counter wrapping at T1MS and a saturating
// 11-bit millisecond count, both restarted by a synchronous clear.
module ms_timer #(
    parameter logic [15:0] T1MS = 16'd49_999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    output logic        tick,
    output logic [10:0] ms_count
);

    logic [15:0] tick_count;

    // tick is high during the last cycle of each millisecond
    assign tick = (tick_count == T1MS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_count <= '0;
            ms_count   <= '0;
        end else if (clr) begin
            tick_count <= '0;
            ms_count   <= '0;
        end else if (tick) begin
            tick_count <= '0;
            if (ms_count != 11'h7ff) begin
                ms_count <= ms_count + 11'd1;
            end
        end else begin
            tick_count <= tick_count + 16'd1;
        end
    end

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority, non-preemptive owner selection for the shared active-low
// buzzer pad, with a watchdog on each grant and a silent gap between owners.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int          NUM_REQ = 3,
    parameter logic [15:0] T1MS    = 16'd49_999,
    parameter logic [10:0] GAP_MS  = 11'd20,
    parameter logic [10:0] MAX_MS  = 11'd1000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [NUM_REQ-1:0] Pin_Req,
    output logic [NUM_REQ-1:0] Grant,
    output logic               Pin_Out,
    output logic               Busy,
    output logic               Timeout
);

    state_t             state;
    state_t             state_next;
    logic [NUM_REQ-1:0] lock;
    logic [NUM_REQ-1:0] lock_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick;
    logic               pin_next;
    logic               timeout_next;
    logic               owner_req;
    logic               owner_pin;

    logic               tick;
    logic               clr;
    logic [10:0]        ms_count;
    logic [11:0]        ms_reach;
    logic               gap_done;
    logic               max_hit;

    ms_timer #(
        .T1MS(T1MS)
    ) u_ms_timer (
        .clk     (CLK),
        .rst     (RST),
        .clr     (clr),
        .tick    (tick),
        .ms_count(ms_count)
    );

    // ms_reach is the count the timer will hold after this edge, so a limit of
    // N ms ends a state after exactly N*(T1MS+1) cycles; a limit of 0 ends it
    // after one cycle.
    assign ms_reach = {1'b0, ms_count} + {11'd0, tick};
    assign gap_done = (ms_reach >= {1'b0, GAP_MS});
    assign max_hit  = (ms_reach >= {1'b0, MAX_MS});

    assign eligible  = Req & ~lock;
    assign owner_req = |(Grant & Req);
    assign owner_pin = |(Grant & Pin_Req);

    always_comb begin
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        grant_next   = Grant;
        pin_next     = PIN_SILENT;
        timeout_next = 1'b0;
        lock_next    = lock & Req;
        case (state)
            IDLE: begin
                grant_next = '0;
                if (|eligible) begin
                    state_next = GRANT;
                    grant_next = pick;
                end
            end
            GRANT: begin
                // A dropped request wins over a simultaneous watchdog expiry.
                if (!owner_req) begin
                    state_next = GAP;
                    grant_next = '0;
                end else if (max_hit) begin
                    state_next   = GAP;
                    grant_next   = '0;
                    timeout_next = 1'b1;
                    lock_next    = (lock & Req) | Grant;
                end else begin
                    pin_next = owner_pin;
                end
            end
            GAP: begin
                grant_next = '0;
                if (gap_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Every state change restarts the timebase so no partial ms carries over.
    assign clr = (state_next != state);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            Grant   <= '0;
            Pin_Out <= PIN_SILENT;
            Timeout <= 1'b0;
            lock    <= '0;
        end else begin
            state   <= state_next;
            Grant   <= grant_next;
            Pin_Out <= pin_next;
            Timeout <= timeout_next;
            lock    <= lock_next;
        end
    end

    assign Busy = is_busy(state);

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Bench for buzzer_arbiter: two builds (2 ms and 0 ms gap) driven in parallel
// and compared every cycle against a cycle-count reference model.
module tb_buzzer_arbiter;

    localparam int NUM_REQ = 3;
    localparam int T1MS    = 9;
    localparam int MS_CYC  = T1MS + 1;
    localparam int MAX_MS  = 5;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] Req = 3'b000;
    logic [2:0] Pin_Req = 3'b111;

    logic [2:0] grant_a, grant_b;
    logic       pin_a, pin_b, busy_a, busy_b, to_a, to_b;

    int n_cmp = 0;
    int n_bad = 0;

    buzzer_arbiter #(
        .NUM_REQ(NUM_REQ), .T1MS(16'd9), .GAP_MS(11'd2), .MAX_MS(11'd5)
    ) dut (
        .CLK(CLK), .RST(RST), .Req(Req), .Pin_Req(Pin_Req),
        .Grant(grant_a), .Pin_Out(pin_a), .Busy(busy_a), .Timeout(to_a)
    );

    buzzer_arbiter #(
        .NUM_REQ(NUM_REQ), .T1MS(16'd9), .GAP_MS(11'd0), .MAX_MS(11'd5)
    ) dut_g0 (
        .CLK(CLK), .RST(RST), .Req(Req), .Pin_Req(Pin_Req),
        .Grant(grant_b), .Pin_Out(pin_b), .Busy(busy_b), .Timeout(to_b)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner index, cycles owned so far, gap cycles left.
    int         owner[2]    = '{-1, -1};
    int         held[2]     = '{0, 0};
    int         gap_left[2] = '{0, 0};
    logic [2:0] lock_m[2]   = '{3'b000, 3'b000};
    logic [2:0] e_grant[2]  = '{3'b000, 3'b000};
    logic       e_pin[2]    = '{1'b1, 1'b1};
    logic       e_to[2]     = '{1'b0, 1'b0};
    logic       e_busy[2]   = '{1'b0, 1'b0};

    task automatic model_reset(input int m);
        owner[m] = -1; held[m] = 0; gap_left[m] = 0; lock_m[m] = 3'b000;
        e_grant[m] = 3'b000; e_pin[m] = 1'b1; e_to[m] = 1'b0; e_busy[m] = 1'b0;
    endtask

    task automatic model_step(input int m, input int gap_ms);
        logic [2:0] elig;
        int pick;
        bit release_now;
        elig = Req & ~lock_m[m];
        lock_m[m] = lock_m[m] & Req;
        e_to[m] = 1'b0;
        e_pin[m] = 1'b1;
        release_now = 1'b0;
        if (owner[m] >= 0) begin
            held[m]++;
            if (!Req[owner[m]]) begin
                release_now = 1'b1;
            end else if (held[m] >= MAX_MS * MS_CYC) begin
                release_now = 1'b1;
                e_to[m] = 1'b1;
                lock_m[m][owner[m]] = 1'b1;
            end else begin
                e_pin[m] = Pin_Req[owner[m]];
            end
            if (release_now) begin
                owner[m] = -1;
                gap_left[m] = (gap_ms * MS_CYC > 0) ? gap_ms * MS_CYC : 1;
            end
        end else if (gap_left[m] > 0) begin
            gap_left[m]--;
        end else begin
            pick = -1;
            for (int k = NUM_REQ - 1; k >= 0; k--) if (elig[k]) pick = k;
            if (pick >= 0) begin
                owner[m] = pick;
                held[m] = 0;
            end
        end
        e_grant[m] = (owner[m] >= 0) ? (3'b001 << owner[m]) : 3'b000;
        e_busy[m] = (owner[m] >= 0) || (gap_left[m] > 0);
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, 2);
            model_step(1, 0);
        end
    end

    // scoreboard: every cycle, both builds against the model
    always @(negedge CLK) begin
        check("a_grant", grant_a, e_grant[0]);
        check("a_pin", pin_a, e_pin[0]);
        check("a_busy", busy_a, e_busy[0]);
        check("a_timeout", to_a, e_to[0]);
        check("b_grant", grant_b, e_grant[1]);
        check("b_pin", pin_b, e_pin[1]);
        check("b_busy", busy_b, e_busy[1]);
        check("b_timeout", to_b, e_to[1]);
    end

    // driver: inputs change just after the falling edge
    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    initial begin
        int k;
        logic [2:0] pr;
        logic [2:0] req_v;

        step(3);
        RST = 1'b0;
        step(2);
        check("rst_grant", grant_a, 3'b000);
        check("rst_pin", pin_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_timeout", to_a, 1'b0);

        // asynchronous reset in the middle of a grant
        Req = 3'b001;
        step(1);
        check("first_grant", grant_a, 3'b001);
        step(3);
        RST = 1'b1;
        #1;
        check("midrst_grant", grant_a, 3'b000);
        check("midrst_pin", pin_a, 1'b1);
        check("midrst_busy", busy_a, 1'b0);
        step(2);
        RST = 1'b0;
        step(1);
        check("post_rst_grant", grant_a, 3'b001);
        Req = 3'b000;
        step(25);

        // priority and non-preemption
        Pin_Req = 3'b000;
        Req = 3'b110;
        step(1);
        check("prio_grant", grant_a, 3'b010);
        Req = 3'b111;
        step(10);
        check("no_preempt", grant_a, 3'b010);
        Req = 3'b101;
        step(1);
        check("release_grant", grant_a, 3'b000);
        check("gap_busy", busy_a, 1'b1);
        check("gap_pin", pin_a, 1'b1);
        step(19);
        check("gap_end_grant", grant_a, 3'b000);
        check("gap_end_busy", busy_a, 1'b1);
        step(1);
        check("idle_busy", busy_a, 1'b0);
        check("idle_grant", grant_a, 3'b000);
        step(1);
        check("after_gap_grant", grant_a, 3'b001);

        // pass-through with one cycle of latency
        for (int i = 0; i < 6; i++) begin
            pr = 3'($urandom_range(0, 7));
            if (i < 3) pr[0] = (i == 1);
            Pin_Req = pr;
            step(1);
            check("pass_a", pin_a, pr[0]);
            check("pass_b", pin_b, pr[0]);
        end

        // watchdog on client 2
        Req = 3'b100;
        k = 0;
        while (grant_a !== 3'b100 && k < 100) begin
            step(1);
            k++;
        end
        check("to_grant", grant_a, 3'b100);
        k = 0;
        while (to_a !== 1'b1 && k < 200) begin
            step(1);
            k++;
        end
        check("to_latency", k, 50);
        check("to_grant_off", grant_a, 3'b000);
        step(1);
        check("to_single_pulse", to_a, 1'b0);
        step(40);
        check("locked_no_regrant", grant_a, 3'b000);
        check("locked_idle", busy_a, 1'b0);
        Req = 3'b000;
        step(1);
        Req = 3'b100;
        step(1);
        check("unlock_regrant", grant_a, 3'b100);

        // request drop on the same cycle as watchdog expiry
        Req = 3'b000;
        step(25);
        Req = 3'b001;
        step(1);
        check("sim_grant", grant_a, 3'b001);
        step(49);
        Req = 3'b000;
        step(1);
        check("sim_no_timeout", to_a, 1'b0);
        check("sim_grant_off", grant_a, 3'b000);
        Req = 3'b001;
        step(1);
        check("sim_still_quiet", to_a, 1'b0);
        step(21);
        check("sim_not_locked", grant_a, 3'b001);

        // zero-length gap build: one GAP cycle, then IDLE, then the next owner
        Req = 3'b000;
        step(25);
        Req = 3'b011;
        step(1);
        check("g0_first", grant_b, 3'b001);
        Req = 3'b010;
        step(1);
        check("g0_release", grant_b, 3'b000);
        check("g0_gap_busy", busy_b, 1'b1);
        step(1);
        check("g0_idle", grant_b, 3'b000);
        step(1);
        check("g0_next", grant_b, 3'b010);
        Req = 3'b011;
        step(3);
        Req = 3'b001;
        step(3);
        check("g0_alternate", grant_b, 3'b001);

        // randomized traffic, checked by the scoreboard
        req_v = 3'b000;
        for (int c = 0; c < 4000; c++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ($urandom_range(0, 34) == 0) req_v[j] = ~req_v[j];
            end
            Req = req_v;
            Pin_Req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) begin
                RST = 1'b1;
                step(2);
                RST = 1'b0;
            end
            step(1);
        end

        Req = 3'b000;
        step(30);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
- Shares the single active-low buzzer pin between NUM_REQ independent requesters: the SOS sequencer, key-click beeper and alarm tick.
- Fixed-priority, non-preemptive arbiter with a per-grant watchdog timeout and a silent guard gap between owners.
- Sits between the buzzer-pattern modules and the top-level buzzer pad.
- Each client drives its own pin-level request; only the granted client reaches the pad.

Parameters:
- NUM_REQ, 3, number of requesters. Index 0 has the highest priority.
- T1MS, 16'd49_999, clock cycles per millisecond minus one (50 MHz clock).
- GAP_MS, 11'd20, silent guard time in ms after every release.
- MAX_MS, 11'd1000, maximum grant duration in ms before forced release.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- Req  in  NUM_REQ  level request per client. Held high for as long as the client wants the buzzer.
- Pin_Req  in  NUM_REQ  per-client buzzer drive (0 = sound). Ignored unless that client is granted.
- Grant  out  NUM_REQ  one-hot grant, registered.
- Pin_Out  out  1  buzzer pad drive, active-low (1 = silent), registered.
- Busy  out  1  high in GRANT and GAP states.
- Timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (asynchronous, any state, including mid-grant):
  - Grant=0, Pin_Out=1, Busy=0, Timeout=0.
  - Lock=0, state=IDLE, ms/tick counters=0.
- Eligible[k] = Req[k] & ~Lock[k].
- States:
  - IDLE: if any Eligible, select the lowest index k. Next edge: Grant=onehot(k), state=GRANT, Busy=1, counters cleared. With nothing eligible, stay IDLE with Pin_Out=1.
  - GRANT: each cycle, Pin_Out <= Pin_Req[k], giving one cycle of latency. A higher-priority request does not preempt.
    - If Req[k] is sampled low: next edge Grant=0, Pin_Out=1, state=GAP.
    - Else if the ms count reaches MAX_MS: next edge Grant=0, Pin_Out=1, Timeout=1 for one cycle, Lock[k]=1, state=GAP.
    - If Req drop and timeout occur in the same cycle, it is a normal release: no Timeout, no Lock.
  - GAP: Pin_Out=1, Grant=0, Busy=1. Lasts exactly GAP_MS*(T1MS+1) cycles counted from entry, then IDLE with Busy=0. GAP_MS=0 gives one GAP cycle.
- Lock[k] clears on any cycle where Req[k] is low, in any state. A locked client must drop Req before it can win again.
- Millisecond timing:
  - The tick counter counts 0..T1MS and wraps.
  - The ms counter increments on wrap.
  - Both counters are cleared on every state entry, so timing is exact and never inherits a partial ms.
  - The ms counter is 11 bits and saturates, never wraps.
- Requests that change during GAP take effect only at IDLE arbitration.
- Minimum turnaround back to back (release → next grant) is GAP + 1 IDLE cycle.

Decomposition:
- Shared package buzzer_pkg holds:
  - state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2);
  - requester index constants (REQ_SOS=0, REQ_ALARM=1, REQ_KEY=2);
  - PIN_SILENT=1'b1.
- One sub-module, ms_timer: synchronous clear input, tick and ms-count outputs, parameterised by T1MS. This block instantiates it once; the SOS and other pattern modules reuse it.

Test Plan (simulation overrides T1MS=9, GAP_MS=2, MAX_MS=5):
- Reset check: assert RST mid-GRANT → same cycle Grant=000, Pin_Out=1, Busy=0. After release, Req=001 → Grant=001 one cycle later.
- Priority and non-preemption:
  - Req=110 in IDLE → Grant=010.
  - Raise Req[0] during the grant → Grant stays 010 until Req[1] drops.
  - After 20 GAP cycles → Grant=001.
- Pass-through: granted client 0 toggles Pin_Req[0] 0/1/0 → Pin_Out follows with exactly one cycle delay. Pin_Req[2] toggling has no effect; ungranted Pin_Out stays 1.
- Timeout:
  - Hold Req[2]=1 → forced release at 50 cycles after grant, Timeout pulses once, Grant=000, GAP of 20 cycles.
  - Req[2] still high → no regrant.
  - Drop then reassert → granted again.
- Simultaneous: drop Req[0] on the exact cycle the ms count reaches MAX_MS → Timeout stays 0, Lock[0] stays 0.
- Gap boundary: GAP_MS=0 build → exactly one GAP cycle between release and next grant. Back-to-back requesters alternate correctly.
